ddr2_cmd_arbiter: RTL and testbench
===================================

DDR2_CMD_ARBITER -- requirements
Module: ddr2_cmd_arbiter

Interface
REQ-001 Parameters (name, default, meaning): BA_BITS, 3, bank width; ADDR_BITS, 13, row/col width; NUM_CH, 2, user channels; TREFI_CYC, 1560, refresh interval in ck cycles; MAX_PEND, 8, refresh backlog limit; REF_POSTPONE, 0, 1 = defer refresh while requests pend.
REQ-002 One clock; reset is synchronous and active-low; ports listed as name direction width meaning.
REQ-003 ck  in  1  system clock, all logic on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 init_end in 1, init_cke in 1, init_cmd in 4, init_ba in BA_BITS, init_addr in ADDR_BITS: init sequencer outputs.
REQ-006 aref_en out 1 refresh start pulse; aref_cmd in 4; aref_addr in ADDR_BITS; aref_end in 1 refresh done pulse.
REQ-007 ch_req in NUM_CH request; ch_wr in NUM_CH 1=write 0=read; ch_gnt out NUM_CH one-hot grant; ch_done out NUM_CH one-cycle completion pulse.
REQ-008 wr_en out 1, rd_en out 1: engine start pulses; eng_cmd in 4; eng_ba in BA_BITS; eng_addr in ADDR_BITS; eng_end in 1 engine done pulse.
REQ-009 ddr2_cke out 1; ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n out 1 each; ddr2_ba out BA_BITS; ddr2_addr out ADDR_BITS; ref_ovf out 1 sticky backlog overflow.

Function
REQ-010 One-hot FSM, states INIT, IDLE, AREF, WRITE, READ; reset state INIT.
REQ-011 INIT -> IDLE when init_end=1; refresh timer and backlog held at 0 while in INIT.
REQ-012 Refresh timer counts ck cycles from leaving INIT; at TREFI_CYC-1 wraps to 0 and raises tick for one cycle.
REQ-013 Backlog pend (width clog2(MAX_PEND+1)): +1 on tick, -1 on aref_end, unchanged if both same cycle; tick at pend=MAX_PEND leaves pend unchanged and sets ref_ovf until reset.
REQ-014 IDLE decision per cycle, priority order: (a) pend>0 and (REF_POSTPONE=0 or ch_req=0 or pend=MAX_PEND) -> AREF; (b) any ch_req -> WRITE if winner ch_wr=1 else READ; (c) stay IDLE.
REQ-015 Winner chosen round-robin: first asserted ch_req at or after pointer, wrapping at NUM_CH; pointer reset 0; on grant pointer = winner+1 mod NUM_CH.
REQ-016 Entering AREF: aref_en=1 for exactly one cycle (the first AREF cycle); AREF -> IDLE on aref_end.
REQ-017 Entering WRITE/READ: wr_en or rd_en=1 for one cycle; ch_gnt one-hot for winner held for whole WRITE/READ stay; ch_req sampled only in IDLE.
REQ-018 WRITE/READ -> IDLE on eng_end; same cycle ch_done[winner]=1, ch_gnt cleared next cycle.
REQ-019 At most one of aref_en, wr_en, rd_en high in any cycle; ch_gnt zero outside WRITE/READ.
REQ-020 Command outputs registered, one-cycle latency from source: INIT selects init_*, AREF aref_cmd/aref_addr with ba=0, WRITE/READ eng_*, IDLE NOP {cs_n,ras_n,cas_n,we_n}=4'b0111 with ba/addr held.
REQ-021 ddr2_cke = init_cke registered; held 1 after init_end.
REQ-022 aref_end or eng_end arriving in a state not expecting it is ignored.

Reset
REQ-023 rst_n=0 sampled at ck edge: state INIT, cmd outputs 4'b1111, ddr2_ba=0, ddr2_addr=0, ddr2_cke=0, aref_en=wr_en=rd_en=0, ch_gnt=0, ch_done=0, pend=0, timer=0, pointer=0, ref_ovf=0.
REQ-024 Reset mid-AREF/WRITE/READ aborts immediately with no completion pulse; re-init required.

Verification
REQ-025 Init: init_end at cycle 20 -> IDLE at 21, NOP on bus at 22, ddr2_cke follows init_cke with 1-cycle lag.
REQ-026 Refresh: TREFI_CYC=16, no requests -> aref_en every 16 cycles after init; aref_end 3 cycles later -> pend returns 0.
REQ-027 Round-robin: NUM_CH=2, both ch_req held, eng_end 2 cycles after start -> grants alternate ch0, ch1, ch0; ch_done matches grant.
REQ-028 Postpone: REF_POSTPONE=1, MAX_PEND=2, continuous requests -> refresh deferred until pend=2, then AREF twice before next grant; REF_POSTPONE=0 -> AREF preempts at next IDLE.
REQ-029 Overflow: aref_end never returned, MAX_PEND=2 -> ref_ovf=1 on third tick, pend stays 2.
REQ-030 Reset during WRITE -> next cycle all outputs at REQ-023 values, no ch_done.

Source files
------------

// File: rtl/ddr2_cmd_arbiter.sv
// ddr2_cmd_arbiter: sequences init, auto-refresh and round-robin user read/write access onto one DDR2 command bus
module ddr2_cmd_arbiter #(
    parameter int BA_BITS      = 3,
    parameter int ADDR_BITS    = 13,
    parameter int NUM_CH       = 2,
    parameter int TREFI_CYC    = 1560,
    parameter int MAX_PEND     = 8,
    parameter int REF_POSTPONE = 0
) (
    input  logic                 ck,
    input  logic                 rst_n,
    input  logic                 init_end,
    input  logic                 init_cke,
    input  logic [3:0]           init_cmd,
    input  logic [BA_BITS-1:0]   init_ba,
    input  logic [ADDR_BITS-1:0] init_addr,
    output logic                 aref_en,
    input  logic [3:0]           aref_cmd,
    input  logic [ADDR_BITS-1:0] aref_addr,
    input  logic                 aref_end,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH-1:0]    ch_wr,
    output logic [NUM_CH-1:0]    ch_gnt,
    output logic [NUM_CH-1:0]    ch_done,
    output logic                 wr_en,
    output logic                 rd_en,
    input  logic [3:0]           eng_cmd,
    input  logic [BA_BITS-1:0]   eng_ba,
    input  logic [ADDR_BITS-1:0] eng_addr,
    input  logic                 eng_end,
    output logic                 ddr2_cke,
    output logic                 ddr2_cs_n,
    output logic                 ddr2_ras_n,
    output logic                 ddr2_cas_n,
    output logic                 ddr2_we_n,
    output logic [BA_BITS-1:0]   ddr2_ba,
    output logic [ADDR_BITS-1:0] ddr2_addr,
    output logic                 ref_ovf
);
    localparam int TW = TREFI_CYC > 1 ? $clog2(TREFI_CYC) : 1;
    localparam int PW = $clog2(MAX_PEND + 1);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    typedef enum logic [4:0] {
        INIT  = 5'b00001,
        IDLE  = 5'b00010,
        AREF  = 5'b00100,
        WRITE = 5'b01000,
        READ  = 5'b10000
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [PW-1:0]   pend;
    logic [CW-1:0]   ptr;
    logic [CW-1:0]   win;
    logic [NUM_CH-1:0] rot;
    logic            tick;
    logic            ref_done;
    logic            go_aref;

    // rot puts the pointer channel at bit 0; the lowest set bit of rot is the round-robin winner
    always_comb begin
        tick     = state != INIT && timer == TW'(TREFI_CYC - 1);
        ref_done = state == AREF && aref_end;
        go_aref  = pend != '0 && (REF_POSTPONE == 0 || ch_req == '0 || pend == PW'(MAX_PEND));
        rot      = NUM_CH'({ch_req, ch_req} >> ptr);
        win      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (rot[i]) win = CW'((int'(ptr) + i) % NUM_CH);
        ch_done  = (rst_n && eng_end && (state == WRITE || state == READ)) ? ch_gnt : '0;
    end

    always_ff @(posedge ck) begin
        if (!rst_n || state == INIT) begin
            timer <= '0;
            pend  <= '0;
        end else begin
            timer <= tick ? '0 : timer + 1'b1;
            if (tick && !ref_done && pend != PW'(MAX_PEND))
                pend <= pend + 1'b1;
            else if (ref_done && !tick && pend != '0)
                pend <= pend - 1'b1;
        end
    end

    always_ff @(posedge ck)
        ref_ovf <= rst_n && (ref_ovf || (tick && !ref_done && pend == PW'(MAX_PEND)));

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state     <= INIT;
            ptr       <= '0;
            ch_gnt    <= '0;
            aref_en   <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            ddr2_cke  <= 1'b0;
            {ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n} <= 4'b1111;
            ddr2_ba   <= '0;
            ddr2_addr <= '0;
        end else begin
            aref_en  <= 1'b0;
            wr_en    <= 1'b0;
            rd_en    <= 1'b0;
            ddr2_cke <= state == INIT ? init_cke : 1'b1;
            case (state)
                INIT: begin
                    {ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n} <= init_cmd;
                    ddr2_ba   <= init_ba;
                    ddr2_addr <= init_addr;
                    if (init_end) state <= IDLE;
                end
                IDLE: begin
                    {ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n} <= 4'b0111;
                    if (go_aref) begin
                        state   <= AREF;
                        aref_en <= 1'b1;
                    end else if (ch_req != '0) begin
                        state  <= ch_wr[win] ? WRITE : READ;
                        wr_en  <= ch_wr[win];
                        rd_en  <= !ch_wr[win];
                        ch_gnt <= NUM_CH'(1) << win;
                        ptr    <= win == CW'(NUM_CH - 1) ? '0 : win + 1'b1;
                    end
                end
                AREF: begin
                    {ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n} <= aref_cmd;
                    ddr2_ba   <= '0;
                    ddr2_addr <= aref_addr;
                    if (aref_end) state <= IDLE;
                end
                default: begin
                    {ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n} <= eng_cmd;
                    ddr2_ba   <= eng_ba;
                    ddr2_addr <= eng_addr;
                    if (eng_end) begin
                        state  <= IDLE;
                        ch_gnt <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ddr2_cmd_arbiter.sv
// tb_ddr2_cmd_arbiter: random traffic against a behavioural arbiter model, per-cycle scoreboard on every output
module tb_ddr2_cmd_arbiter;
    localparam int BA = 3, AW = 13, NCH = 3, TREFI = 16, MAXP = 2, POST = 1, NCYC = 1500;

    logic ck = 1'b0, rst_n = 1'b0;
    logic init_end = 1'b0, init_cke = 1'b0, aref_end = 1'b0, eng_end = 1'b0;
    logic [3:0] init_cmd = '0, aref_cmd = '0, eng_cmd = '0;
    logic [BA-1:0] init_ba = '0, eng_ba = '0;
    logic [AW-1:0] init_addr = '0, aref_addr = '0, eng_addr = '0;
    logic [NCH-1:0] ch_req = '0, ch_wr = '0, ch_gnt, ch_done;
    logic aref_en, wr_en, rd_en, ddr2_cke, ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n, ref_ovf;
    logic [BA-1:0] ddr2_ba;
    logic [AW-1:0] ddr2_addr;

    ddr2_cmd_arbiter #(.BA_BITS(BA), .ADDR_BITS(AW), .NUM_CH(NCH), .TREFI_CYC(TREFI),
                       .MAX_PEND(MAXP), .REF_POSTPONE(POST)) dut (
        .ck(ck), .rst_n(rst_n), .init_end(init_end), .init_cke(init_cke), .init_cmd(init_cmd),
        .init_ba(init_ba), .init_addr(init_addr), .aref_en(aref_en), .aref_cmd(aref_cmd),
        .aref_addr(aref_addr), .aref_end(aref_end), .ch_req(ch_req), .ch_wr(ch_wr),
        .ch_gnt(ch_gnt), .ch_done(ch_done), .wr_en(wr_en), .rd_en(rd_en), .eng_cmd(eng_cmd),
        .eng_ba(eng_ba), .eng_addr(eng_addr), .eng_end(eng_end), .ddr2_cke(ddr2_cke),
        .ddr2_cs_n(ddr2_cs_n), .ddr2_ras_n(ddr2_ras_n), .ddr2_cas_n(ddr2_cas_n),
        .ddr2_we_n(ddr2_we_n), .ddr2_ba(ddr2_ba), .ddr2_addr(ddr2_addr), .ref_ovf(ref_ovf));

    always #5 ck = ~ck;

    typedef struct packed {
        logic [3:0]     cmd;
        logic [BA-1:0]  ba;
        logic [AW-1:0]  addr;
        logic           cke, aen, wen, ren;
        logic [NCH-1:0] gnt, done;
        logic           ovf;
    } obs_t;

    typedef enum {M_INIT, M_IDLE, M_REF, M_WR, M_RD} mode_t;

    obs_t  exp_q[$];
    obs_t  mon_e, m_out, drv_e;
    mode_t m_mode;
    int    m_pend, m_cyc, m_ptr;
    int    n_cmp = 0, n_bad = 0;
    int    ref_wait = 0, eng_wait = 0, init_cnt = 0;
    bit    first_ref = 1'b1, did_rst = 1'b0, rst_now;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_INIT;
        m_pend = 0;
        m_cyc  = 0;
        m_ptr  = 0;
        m_out  = '0;
        m_out.cmd = 4'b1111;
    endtask

    // advances the reference by one clock edge using the inputs currently driven
    task automatic model_step();
        mode_t nm;
        bit tick, rdone;
        int w, c;
        if (!rst_n) begin
            model_reset();
            return;
        end
        nm    = m_mode;
        tick  = m_mode != M_INIT && (m_cyc % TREFI) == TREFI - 1;
        rdone = m_mode == M_REF && aref_end;
        m_out.aen = 1'b0;
        m_out.wen = 1'b0;
        m_out.ren = 1'b0;
        m_out.cke = m_mode == M_INIT ? init_cke : 1'b1;
        case (m_mode)
            M_INIT: begin
                m_out.cmd = init_cmd; m_out.ba = init_ba; m_out.addr = init_addr;
                if (init_end) nm = M_IDLE;
            end
            M_IDLE: begin
                m_out.cmd = 4'b0111;
                if (m_pend > 0 && (POST == 0 || ch_req == '0 || m_pend == MAXP)) begin
                    nm = M_REF;
                    m_out.aen = 1'b1;
                end else if (ch_req != '0) begin
                    w = -1;
                    for (int j = 0; j < NCH; j++) begin
                        c = (m_ptr + j) % NCH;
                        if (w < 0 && ch_req[c]) w = c;
                    end
                    nm = ch_wr[w] ? M_WR : M_RD;
                    m_out.wen = ch_wr[w];
                    m_out.ren = !ch_wr[w];
                    m_out.gnt = '0;
                    m_out.gnt[w] = 1'b1;
                    m_ptr = (w + 1) % NCH;
                end
            end
            M_REF: begin
                m_out.cmd = aref_cmd; m_out.ba = '0; m_out.addr = aref_addr;
                if (aref_end) nm = M_IDLE;
            end
            default: begin
                m_out.cmd = eng_cmd; m_out.ba = eng_ba; m_out.addr = eng_addr;
                if (eng_end) begin
                    nm = M_IDLE;
                    m_out.gnt = '0;
                end
            end
        endcase
        if (m_mode == M_INIT) begin
            m_cyc  = 0;
            m_pend = 0;
        end else begin
            m_cyc++;
            if (tick && !rdone) begin
                if (m_pend == MAXP) m_out.ovf = 1'b1;
                else m_pend++;
            end else if (rdone && !tick && m_pend > 0) m_pend--;
        end
        if (nm != m_mode && nm == M_REF) begin
            ref_wait  = first_ref ? 40 : $urandom_range(0, 3);
            first_ref = 1'b0;
        end
        if (nm != m_mode && (nm == M_WR || nm == M_RD)) eng_wait = $urandom_range(0, 3);
        m_mode = nm;
    endtask

    initial forever begin
        @(negedge ck);
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("cmd", 32'({ddr2_cs_n, ddr2_ras_n, ddr2_cas_n, ddr2_we_n}), 32'(mon_e.cmd));
            check("ba", 32'(ddr2_ba), 32'(mon_e.ba));
            check("addr", 32'(ddr2_addr), 32'(mon_e.addr));
            check("cke", 32'(ddr2_cke), 32'(mon_e.cke));
            check("aref_en", 32'(aref_en), 32'(mon_e.aen));
            check("wr_en", 32'(wr_en), 32'(mon_e.wen));
            check("rd_en", 32'(rd_en), 32'(mon_e.ren));
            check("ch_gnt", 32'(ch_gnt), 32'(mon_e.gnt));
            check("ch_done", 32'(ch_done), 32'(mon_e.done));
            check("ref_ovf", 32'(ref_ovf), 32'(mon_e.ovf));
        end
    end

    initial begin
        model_reset();
        for (int k = 1; k <= NCYC; k++) begin
            @(posedge ck);
            #2;
            rst_now = !did_rst && k > 900 && m_mode == M_WR;
            if (rst_now) did_rst = 1'b1;
            rst_n = !(k <= 3 || rst_now);
            init_end = rst_n && m_mode == M_INIT && (k == 20 || (did_rst && init_cnt >= 6));
            init_cnt = (!rst_n || m_mode != M_INIT) ? 0 : init_cnt + 1;
            init_cke  = 1'($urandom);
            init_cmd  = 4'($urandom);
            init_ba   = BA'($urandom);
            init_addr = AW'($urandom);
            aref_cmd  = 4'($urandom);
            aref_addr = AW'($urandom);
            eng_cmd   = 4'($urandom);
            eng_ba    = BA'($urandom);
            eng_addr  = AW'($urandom);
            ch_wr     = NCH'($urandom);
            if (k < 300) ch_req = NCH'($urandom);
            else if (k < 500) ch_req = '1;
            else if (k < 600) ch_req = '0;
            else ch_req = NCH'($urandom) & NCH'($urandom);
            if (m_mode == M_REF) begin
                aref_end = ref_wait == 0;
                if (ref_wait > 0) ref_wait--;
            end else aref_end = $urandom_range(0, 15) == 0;
            if (m_mode == M_WR || m_mode == M_RD) begin
                eng_end = eng_wait == 0;
                if (eng_wait > 0) eng_wait--;
            end else eng_end = $urandom_range(0, 15) == 0;
            if (!rst_n) begin
                aref_end = 1'b0;
                eng_end  = 1'b0;
            end
            drv_e = m_out;
            drv_e.done = (rst_n && eng_end && (m_mode == M_WR || m_mode == M_RD)) ? m_out.gnt : '0;
            exp_q.push_back(drv_e);
            model_step();
        end
        repeat (3) @(negedge ck);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("mid_write_reset_hit", 32'(did_rst), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
